counter_sweep_ctrl: RTL and testbench



---
 rtl/counter_sweep_pkg.sv | 19 +
 rtl/counter_sweep_ctrl_dwell_timer.sv | 29 ++
 rtl/counter_sweep_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// Shared types and constants for the counter sweep controller.
// State encoding and mode codes used by the controller and its bench.
package counter_sweep_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSeek,
      StRunUp,
      StRunDn,
      StDwell,
      StFinish
   } state_e;

   localparam logic [1:0] MODE_UP_ONCE   = 2'd0;
   localparam logic [1:0] MODE_DOWN_ONCE = 2'd1;
   localparam logic [1:0] MODE_TRIANGLE  = 2'd2;
   localparam logic [1:0] MODE_ILLEGAL   = 2'd3;

endpackage

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// Loadable down-counter that times the hold at each sweep endpoint.
// Load wins over counting; the count parks at zero.
module dwell_timer #(
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   output logic [DW-1:0] value,
   output logic          expire
);

   logic [DW-1:0] value_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_val;
      end else if (value_q != '0) begin
         value_q <= value_q - DW'(1);
      end
   end

   assign value  = value_q;
   assign expire = (value_q == DW'(1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer steering an up/down counter between programmable bounds.
// Counter controls are combinational from state and live q, so no overshoot.
module counter_sweep_ctrl
   import counter_sweep_pkg::*;
#(
   parameter int unsigned W  = 8,
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    mode,
   input  logic [W-1:0]  lo,
   input  logic [W-1:0]  hi,
   input  logic [7:0]    cycles,
   input  logic [DW-1:0] dwell,
   input  logic [W-1:0]  q,
   output logic          cnt_en,
   output logic          cnt_up,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [7:0]    period_cnt
);

   state_e        state_q, state_d;
   state_e        after_q, after_d;
   logic [1:0]    mode_q;
   logic [W-1:0]  lo_q, hi_q;
   logic [7:0]    cycles_q;
   logic [DW-1:0] dwell_q;
   logic [7:0]    period_q, period_d;
   logic          err_q, err_d;
   logic          capture;
   logic          dwell_load;
   logic [DW-1:0] dwell_value;
   logic          dwell_expire;
   logic [W-1:0]  target;
   logic [7:0]    period_inc;
   state_e        seek_run;

   dwell_timer #(
      .DW(DW)
   ) u_dwell_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (dwell_load),
      .load_val(dwell_q),
      .value   (dwell_value),
      .expire  (dwell_expire)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         after_q  <= StIdle;
         period_q <= '0;
         err_q    <= 1'b0;
         mode_q   <= MODE_UP_ONCE;
         lo_q     <= '0;
         hi_q     <= '0;
         cycles_q <= '0;
         dwell_q  <= '0;
      end else begin
         state_q  <= state_d;
         after_q  <= after_d;
         period_q <= period_d;
         err_q    <= err_d;
         if (capture) begin
            mode_q   <= mode;
            lo_q     <= lo;
            hi_q     <= hi;
            cycles_q <= cycles;
            dwell_q  <= dwell;
         end
      end
   end

   assign period_inc = period_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      after_d    = after_q;
      period_d   = period_q;
      err_d      = 1'b0;
      capture    = 1'b0;
      dwell_load = 1'b0;
      cnt_en     = 1'b0;
      cnt_up     = 1'b0;
      target     = (mode_q == MODE_DOWN_ONCE) ? hi_q : lo_q;
      seek_run   = (mode_q == MODE_DOWN_ONCE) ? StRunDn : StRunUp;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (mode == MODE_ILLEGAL || lo > hi) begin
                  err_d = 1'b1;
               end else begin
                  capture  = 1'b1;
                  period_d = '0;
                  state_d  = StSeek;
               end
            end
         end
         StSeek: begin
            if (q != target) begin
               cnt_en = 1'b1;
               cnt_up = (q < target);
            end else if (dwell_q != '0) begin
               state_d    = StDwell;
               after_d    = seek_run;
               dwell_load = 1'b1;
            end else begin
               state_d = seek_run;
            end
         end
         StRunUp: begin
            if (q != hi_q) begin
               cnt_en = 1'b1;
               cnt_up = 1'b1;
            end else if (mode_q != MODE_TRIANGLE) begin
               state_d = StFinish;
            end else if (dwell_q != '0) begin
               state_d    = StDwell;
               after_d    = StRunDn;
               dwell_load = 1'b1;
            end else begin
               state_d = StRunDn;
            end
         end
         StRunDn: begin
            if (q != lo_q) begin
               cnt_en = 1'b1;
            end else if (mode_q != MODE_TRIANGLE) begin
               state_d = StFinish;
            end else begin
               period_d = period_inc;
               if (cycles_q != '0 && period_inc == cycles_q) begin
                  state_d = StFinish;
               end else if (dwell_q != '0) begin
                  state_d    = StDwell;
                  after_d    = StRunUp;
                  dwell_load = 1'b1;
               end else begin
                  state_d = StRunUp;
               end
            end
         end
         StDwell: begin
            // A zero timer can only mean a missed load; leave rather than stall.
            if (dwell_expire || dwell_value == '0) begin
               state_d = after_q;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort && state_q inside {StSeek, StRunUp, StRunDn, StDwell}) begin
         state_d    = StIdle;
         after_d    = after_q;
         period_d   = period_q;
         dwell_load = 1'b0;
         cnt_en     = 1'b0;
         cnt_up     = 1'b0;
      end

      // Reset freezes the counter in the same cycle so q stays where it was.
      if (!reset) begin
         cnt_en = 1'b0;
         cnt_up = 1'b0;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFinish);
   assign err        = err_q;
   assign period_cnt = period_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl with a behavioural up/down counter in the loop.
// Expected per-cycle traces are generated from the sweep rules, then compared.
module tb_counter_sweep_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned DW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [1:0]    mode;
   logic [W-1:0]  lo, hi;
   logic [7:0]    cycles;
   logic [DW-1:0] dwell;
   logic [W-1:0]  q_fb;
   logic          cnt_en, cnt_up, busy, done, err;
   logic [7:0]    period_cnt;
   logic          ctr_load;
   logic [W-1:0]  ctr_val;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic       up;
      logic       busy;
      logic       done;
      logic [7:0] q;
      logic [7:0] per;
      int         ph;  // 0 seek, 1 up, 2 down, 3 dwell, 4 finish, 5 idle
   } step_t;

   step_t      tr[$];
   logic [7:0] m_q;
   logic [7:0] m_p;

   counter_sweep_ctrl #(
      .W (W),
      .DW(DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .lo        (lo),
      .hi        (hi),
      .cycles    (cycles),
      .dwell     (dwell),
      .q         (q_fb),
      .cnt_en    (cnt_en),
      .cnt_up    (cnt_up),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .period_cnt(period_cnt)
   );

   always #5 clk = ~clk;

   // Stand-in for the 8-bit up/down counter; it has its own load, not the controller reset.
   always @(posedge clk) begin
      if (ctr_load) q_fb <= ctr_val;
      else if (cnt_en) q_fb <= cnt_up ? q_fb + 8'd1 : q_fb - 8'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add(input logic en, input logic up, input logic bz, input logic dn,
                      input int ph);
      step_t s;
      s.en = en; s.up = up; s.busy = bz; s.done = dn; s.q = m_q; s.per = m_p; s.ph = ph;
      tr.push_back(s);
   endtask

   // Move m_q one step per cycle toward bound, then one arrival cycle at the bound.
   task automatic walk(input logic [7:0] bound, input int ph);
      logic up;
      while (m_q != bound) begin
         up = (m_q < bound);
         add(1'b1, up, 1'b1, 1'b0, ph);
         m_q = up ? m_q + 8'd1 : m_q - 8'd1;
      end
      add(1'b0, 1'b0, 1'b1, 1'b0, ph);
   endtask

   task automatic hold(input int n);
      for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 3);
   endtask

   task automatic fin();
      add(1'b0, 1'b0, 1'b1, 1'b1, 4);
      add(1'b0, 1'b0, 1'b0, 1'b0, 5);
   endtask

   task automatic build_trace(input int md, input logic [7:0] l, input logic [7:0] h,
                              input logic [7:0] c, input int dw, input logic [7:0] q0);
      tr.delete();
      m_q = q0;
      m_p = 8'd0;
      walk((md == 1) ? h : l, 0);
      hold(dw);
      if (md == 0) begin
         walk(h, 1);
         fin();
      end else if (md == 1) begin
         walk(l, 2);
         fin();
      end else begin
         forever begin
            walk(h, 1);
            hold(dw);
            walk(l, 2);
            m_p = m_p + 8'd1;
            if (c != 8'd0 && m_p == c) begin
               fin();
               break;
            end
            if (c == 8'd0 && m_p == 8'd4) break;
            hold(dw);
         end
      end
   endtask

   // kind: 0 none, 1 abort, 2 reset, 3 abort that must be ignored
   task automatic run_sweep(input int md, input logic [7:0] l, input logic [7:0] h,
                            input logic [7:0] c, input int dw,
                            input int kind, input int stop_ph, input logic [7:0] stop_q);
      int stop_at;
      @(negedge clk);
      start = 1'b1; mode = 2'(md); lo = l; hi = h; cycles = c; dwell = DW'(dw);
      #1;
      chk("idle_busy", busy, 1'b0);
      chk("idle_en", cnt_en, 1'b0);
      build_trace(md, l, h, c, dw, q_fb);
      stop_at = -1;
      if (kind != 0) begin
         for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].ph == stop_ph && tr[i].q == stop_q) begin
               stop_at = i;
               break;
            end
         end
         chk("stop_point_found", (stop_at >= 0), 1'b1);
      end
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom); lo = 8'($urandom); hi = 8'($urandom);
      cycles = 8'($urandom); dwell = DW'($urandom);
      for (int i = 0; i < tr.size(); i++) begin
         if (i == stop_at && (kind == 1 || kind == 2)) begin
            if (kind == 1) abort = 1'b1;
            else reset = 1'b0;
            #1;
            chk("stop_en", cnt_en, 1'b0);
            chk("stop_up", cnt_up, 1'b0);
            chk("stop_busy", busy, 1'b1);
            chk("stop_done", done, 1'b0);
            chk("stop_q", q_fb, tr[i].q);
            @(negedge clk);
            abort = 1'b0;
            reset = 1'b1;
            #1;
            chk("after_stop_busy", busy, 1'b0);
            chk("after_stop_done", done, 1'b0);
            chk("after_stop_err", err, 1'b0);
            chk("after_stop_en", cnt_en, 1'b0);
            chk("after_stop_q", q_fb, tr[i].q);
            chk("after_stop_period", period_cnt, (kind == 2) ? 8'd0 : tr[i].per);
            return;
         end
         abort = (i == stop_at && kind == 3);
         #1;
         chk("en", cnt_en, tr[i].en);
         chk("up", cnt_up, tr[i].up);
         chk("busy", busy, tr[i].busy);
         chk("done", done, tr[i].done);
         chk("q", q_fb, tr[i].q);
         chk("period_cnt", period_cnt, tr[i].per);
         chk("err", err, 1'b0);
         if (i < tr.size() - 1) @(negedge clk);
         abort = 1'b0;
      end
   endtask

   task automatic reject(input logic [1:0] md, input logic [7:0] l, input logic [7:0] h);
      @(negedge clk);
      start = 1'b1; mode = md; lo = l; hi = h; cycles = 8'd1; dwell = '0;
      #1;
      chk("rej_en", cnt_en, 1'b0);
      chk("rej_busy", busy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("rej_err_pulse", err, 1'b1);
      chk("rej_busy_after", busy, 1'b0);
      chk("rej_en_after", cnt_en, 1'b0);
      @(negedge clk);
      #1;
      chk("rej_err_clear", err, 1'b0);
      chk("rej_done", done, 1'b0);
   endtask

   initial begin
      logic [7:0] rl, rh;
      reset = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; lo = '0; hi = '0;
      cycles = '0; dwell = '0; ctr_load = 1'b1; ctr_val = 8'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_period", period_cnt, 8'd0);
      chk("rst_en", cnt_en, 1'b0);
      chk("rst_q", q_fb, 8'd0);
      reset = 1'b1;
      ctr_load = 1'b0;

      run_sweep(0, 8'd3, 8'd6, 8'd0, 0, 0, 0, 8'd0);
      run_sweep(1, 8'd2, 8'd5, 8'd0, 2, 0, 0, 8'd0);
      run_sweep(2, 8'd10, 8'd12, 8'd2, 0, 0, 0, 8'd0);
      run_sweep(2, 8'd10, 8'd12, 8'd0, 0, 1, 2, 8'd11);
      reject(2'd0, 8'd9, 8'd4);
      reject(2'd3, 8'd1, 8'd2);
      run_sweep(0, 8'd4, 8'd9, 8'd0, 1, 2, 1, 8'd7);
      run_sweep(1, 8'd2, 8'd8, 8'd0, 0, 0, 0, 8'd0);
      // Endpoints of the range, degenerate bounds and an ignored abort in FINISH.
      run_sweep(0, 8'd253, 8'd255, 8'd0, 0, 3, 4, 8'd255);
      run_sweep(1, 8'd0, 8'd1, 8'd0, 3, 0, 0, 8'd0);
      run_sweep(2, 8'd0, 8'd0, 8'd2, 1, 0, 0, 8'd0);
      run_sweep(0, 8'd5, 8'd5, 8'd0, 0, 0, 0, 8'd0);

      for (int n = 0; n < 8; n++) begin
         rl = 8'($urandom_range(0, 255));
         rh = (rl > 8'd250) ? 8'd255 : rl + 8'($urandom_range(0, 4));
         run_sweep(int'($urandom_range(0, 2)), rl, rh, 8'($urandom_range(1, 3)),
                   int'($urandom_range(0, 3)), 0, 0, 8'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
